// File: rtl/morse_encoder.sv
// Morse character encoder (transmit side).
// Takes one character code per valid/ready handshake and drives a key line with the
// timed dot/dash pattern for that character. The pattern is followed by the
// inter-character gap, or by a word-space gap for code 36.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   char_valid  char_code is being presented
//   char_code   0-25 A-Z, 26-35 digits 0-9, 36 word space, 37-63 invalid
//   char_ready  encoder can accept a code (IDLE only, combinational)
//   key_out     registered key line, 1 = tone/light on
//   busy        registered, high whenever not IDLE
//   err         registered one-cycle pulse after an invalid code is accepted
module morse_encoder #(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StGap,
        StCharGap,
        StSpace,
        StErr
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cyc_q;
    logic [2:0]    unit_q;
    logic [4:0]    pat_q;    // left-aligned, bit 4 is the current element (1 = dash)
    logic [2:0]    elems_q;  // elements remaining, including the current one

    logic [2:0] rom_len;
    logic [4:0] rom_pat;
    logic [2:0] need_units;
    logic       cyc_last;
    logic       unit_done;

    // Symbol ROM: length and left-aligned pattern, first element in bit 4.
    always_comb begin
        rom_len = 3'd0;
        rom_pat = 5'b00000;
        case (char_code)
            6'd0:  {rom_len, rom_pat} = {3'd2, 5'b01000}; // A .-
            6'd1:  {rom_len, rom_pat} = {3'd4, 5'b10000}; // B -...
            6'd2:  {rom_len, rom_pat} = {3'd4, 5'b10100}; // C -.-.
            6'd3:  {rom_len, rom_pat} = {3'd3, 5'b10000}; // D -..
            6'd4:  {rom_len, rom_pat} = {3'd1, 5'b00000}; // E .
            6'd5:  {rom_len, rom_pat} = {3'd4, 5'b00100}; // F ..-.
            6'd6:  {rom_len, rom_pat} = {3'd3, 5'b11000}; // G --.
            6'd7:  {rom_len, rom_pat} = {3'd4, 5'b00000}; // H ....
            6'd8:  {rom_len, rom_pat} = {3'd2, 5'b00000}; // I ..
            6'd9:  {rom_len, rom_pat} = {3'd4, 5'b01110}; // J .---
            6'd10: {rom_len, rom_pat} = {3'd3, 5'b10100}; // K -.-
            6'd11: {rom_len, rom_pat} = {3'd4, 5'b01000}; // L .-..
            6'd12: {rom_len, rom_pat} = {3'd2, 5'b11000}; // M --
            6'd13: {rom_len, rom_pat} = {3'd2, 5'b10000}; // N -.
            6'd14: {rom_len, rom_pat} = {3'd3, 5'b11100}; // O ---
            6'd15: {rom_len, rom_pat} = {3'd4, 5'b01100}; // P .--.
            6'd16: {rom_len, rom_pat} = {3'd4, 5'b11010}; // Q --.-
            6'd17: {rom_len, rom_pat} = {3'd3, 5'b01000}; // R .-.
            6'd18: {rom_len, rom_pat} = {3'd3, 5'b00000}; // S ...
            6'd19: {rom_len, rom_pat} = {3'd1, 5'b10000}; // T -
            6'd20: {rom_len, rom_pat} = {3'd3, 5'b00100}; // U ..-
            6'd21: {rom_len, rom_pat} = {3'd4, 5'b00010}; // V ...-
            6'd22: {rom_len, rom_pat} = {3'd3, 5'b01100}; // W .--
            6'd23: {rom_len, rom_pat} = {3'd4, 5'b10010}; // X -..-
            6'd24: {rom_len, rom_pat} = {3'd4, 5'b10110}; // Y -.--
            6'd25: {rom_len, rom_pat} = {3'd4, 5'b11000}; // Z --..
            6'd26: {rom_len, rom_pat} = {3'd5, 5'b11111}; // 0
            6'd27: {rom_len, rom_pat} = {3'd5, 5'b01111}; // 1
            6'd28: {rom_len, rom_pat} = {3'd5, 5'b00111}; // 2
            6'd29: {rom_len, rom_pat} = {3'd5, 5'b00011}; // 3
            6'd30: {rom_len, rom_pat} = {3'd5, 5'b00001}; // 4
            6'd31: {rom_len, rom_pat} = {3'd5, 5'b00000}; // 5
            6'd32: {rom_len, rom_pat} = {3'd5, 5'b10000}; // 6
            6'd33: {rom_len, rom_pat} = {3'd5, 5'b11000}; // 7
            6'd34: {rom_len, rom_pat} = {3'd5, 5'b11100}; // 8
            6'd35: {rom_len, rom_pat} = {3'd5, 5'b11110}; // 9
            default: {rom_len, rom_pat} = {3'd0, 5'b00000};
        endcase
    end

    // Units the current state must last.
    always_comb begin
        need_units = 3'd1;
        case (state_q)
            StMark:    need_units = pat_q[4] ? 3'd3 : 3'd1;
            StGap:     need_units = 3'd1;
            StCharGap: need_units = 3'd3;
            StSpace:   need_units = 3'd4;
            default:   need_units = 3'd1;
        endcase
    end

    assign cyc_last   = (cyc_q == CW'(UNIT_CYCLES - 1));
    assign unit_done  = cyc_last && (unit_q == need_units - 3'd1);
    assign char_ready = (state_q == StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            unit_q  <= 3'd0;
            pat_q   <= 5'b00000;
            elems_q <= 3'd0;
            key_out <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (char_valid) begin
                        cyc_q  <= '0;
                        unit_q <= 3'd0;
                        busy   <= 1'b1;
                        if (char_code < 6'd36) begin
                            state_q <= StMark;
                            pat_q   <= rom_pat;
                            elems_q <= rom_len;
                            key_out <= 1'b1;
                        end else if (char_code == 6'd36) begin
                            state_q <= StSpace;
                        end else begin
                            state_q <= StErr;
                            err     <= 1'b1;
                        end
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    if (unit_done) begin
                        cyc_q  <= '0;
                        unit_q <= 3'd0;
                        case (state_q)
                            StMark: begin
                                key_out <= 1'b0;
                                if (elems_q > 3'd1) begin
                                    state_q <= StGap;
                                    pat_q   <= {pat_q[3:0], 1'b0};
                                    elems_q <= elems_q - 3'd1;
                                end else begin
                                    state_q <= StCharGap;
                                end
                            end
                            StGap: begin
                                state_q <= StMark;
                                key_out <= 1'b1;
                            end
                            default: begin
                                state_q <= StIdle;
                                busy    <= 1'b0;
                            end
                        endcase
                    end else if (cyc_last) begin
                        cyc_q  <= '0;
                        unit_q <= unit_q + 3'd1;
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES = 4. Outputs are sampled on the
// falling clock edge; expected key patterns are given as run lengths (high first).
module tb_morse_encoder;

    logic       clk;
    logic       rst;
    logic       char_valid;
    logic [5:0] char_code;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err;

    int total;
    int bad;

    typedef int runs_t[12];

    morse_encoder #(.UNIT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .char_valid(char_valid),
        .char_code (char_code),
        .char_ready(char_ready),
        .key_out   (key_out),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected key level at sample t from alternating high/low run lengths.
    function automatic logic key_at(input runs_t r, input int t);
        int acc;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            acc += r[i];
            if (t < acc) return ((i % 2) == 0);
        end
        return 1'b0;
    endfunction

    // Present a code for one accept edge, return on the following falling edge.
    task automatic send(input logic [5:0] code);
        char_code  = code;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    // Check one character: key pattern, busy for busy_len samples, then idle.
    task automatic run_char(input string name, input logic [5:0] code, input runs_t r,
                            input int busy_len);
        logic exp_k;
        logic exp_b;
        send(code);
        for (int t = 0; t <= busy_len; t++) begin
            exp_k = key_at(r, t);
            exp_b = (t < busy_len);
            total++;
            if (key_out !== exp_k) begin
                bad++;
                $display("FAIL %s_key t=%0d got=%b exp=%b", name, t, key_out, exp_k);
            end
            total++;
            if (busy !== exp_b) begin
                bad++;
                $display("FAIL %s_busy t=%0d got=%b exp=%b", name, t, busy, exp_b);
            end
            total++;
            if (char_ready !== !exp_b) begin
                bad++;
                $display("FAIL %s_ready t=%0d got=%b exp=%b", name, t, char_ready, !exp_b);
            end
            total++;
            if (err !== 1'b0) begin
                bad++;
                $display("FAIL %s_err t=%0d got=%b exp=0", name, t, err);
            end
            if (t < busy_len) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        char_valid = 1'b0;
        char_code  = 6'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({key_out, busy, err} !== 3'b000) begin
                bad++;
                $display("FAIL reset_outs cyc=%0d got=%b exp=000", i, {key_out, busy, err});
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (char_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", char_ready);
        end
        total++;
        if ({key_out, busy, err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_after got=%b exp=000", {key_out, busy, err});
        end
    endtask

    task automatic test_letter_e();
        runs_t r;
        r = '{default: 0};
        r[0] = 4; r[1] = 12;
        run_char("e", 6'd4, r, 16);
    endtask

    task automatic test_letter_a();
        runs_t r;
        r = '{default: 0};
        r[0] = 4; r[1] = 4; r[2] = 12; r[3] = 12;
        run_char("a", 6'd0, r, 32);
    endtask

    task automatic test_digit_zero();
        runs_t r;
        r = '{default: 0};
        for (int i = 0; i < 5; i++) begin
            r[2 * i]     = 12;
            r[2 * i + 1] = 4;
        end
        r[9] = 12;
        run_char("zero", 6'd26, r, 88);
    endtask

    task automatic test_space();
        runs_t r;
        r = '{default: 0};
        run_char("space", 6'd36, r, 16);
    endtask

    // E then T with char_valid held; char_code switches to T while E is in flight.
    task automatic test_back_to_back();
        runs_t r;
        logic  exp_k;
        logic  exp_b;
        r = '{default: 0};
        r[0] = 4; r[1] = 13; r[2] = 12; r[3] = 12;
        char_code  = 6'd4;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_code = 6'd19;
        for (int t = 0; t <= 41; t++) begin
            if (t == 17) char_valid = 1'b0;
            exp_k = key_at(r, t);
            exp_b = (t < 16) || (t >= 17 && t < 41);
            total++;
            if (key_out !== exp_k) begin
                bad++;
                $display("FAIL b2b_key t=%0d got=%b exp=%b", t, key_out, exp_k);
            end
            total++;
            if (busy !== exp_b) begin
                bad++;
                $display("FAIL b2b_busy t=%0d got=%b exp=%b", t, busy, exp_b);
            end
            @(negedge clk);
        end
        char_valid = 1'b0;
    endtask

    task automatic test_invalid();
        send(6'd50);
        total++;
        if ({err, busy, key_out, char_ready} !== 4'b1100) begin
            bad++;
            $display("FAIL inv_first got=%b exp=1100", {err, busy, key_out, char_ready});
        end
        @(negedge clk);
        total++;
        if ({err, busy, key_out, char_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL inv_second got=%b exp=0001", {err, busy, key_out, char_ready});
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL inv_err_clear got=%b exp=0", err);
        end
    endtask

    task automatic test_reset_mid();
        send(6'd0);
        repeat (10) @(negedge clk);
        total++;
        if (key_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_key got=%b exp=1", key_out);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (key_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_key got=%b exp=0", key_out);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_busy got=%b exp=0", busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            total++;
            if ({key_out, busy, err, char_ready} !== 4'b0001) begin
                bad++;
                $display("FAIL mid_after t=%0d got=%b exp=0001", t,
                         {key_out, busy, err, char_ready});
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_letter_e();
        test_letter_a();
        test_digit_zero();
        test_back_to_back();
        test_space();
        test_invalid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Transmit side of the Morse translator: accepts one character code at a time over a valid/ready handshake and drives a single key line with the correctly timed dot/dash pattern. The key line feeds the LED or buzzer driver. It is the output counterpart of the debounced key-input path.

## Interface
- `UNIT_CYCLES`, default 12_500_000: clock cycles per Morse time unit (125 ms at 100 MHz). Must be ≥ 2. The unit counter is $clog2(UNIT_CYCLES) bits wide.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `char_valid`  input  1  `char_code` is presented for transmission.
- `char_code`  input  6  0–25 = A–Z, 26–35 = digits 0–9, 36 = word space, 37–63 = invalid.
- `char_ready`  output  1  encoder can accept a code. High only in IDLE; combinational from state.
- `key_out`  output  1  registered; 1 = tone/light on.
- `busy`  output  1  registered; 1 whenever state ≠ IDLE.
- `err`  output  1  registered; one-cycle pulse when an invalid code is accepted.

## Operation
- Reset values: state IDLE, `key_out`=0, `busy`=0, `err`=0, counters 0. `char_ready`=1 once `rst` is released.
- Accept occurs on the clock edge where `char_valid`=1 and `char_ready`=1. The code is latched at that edge. `char_valid` while busy is ignored; the code is not consumed.
- Symbol ROM (combinational) maps each code to a length (1–5) and a pattern, MSB-first, 1 = dash. Examples: E=`.`, T=`-`, A=`.-`, S=`...`, O=`---`, 0=`-----`, 5=`.....`. Standard ITU patterns apply for all letters and digits.
- Element timing:
  - dot = 1 unit on
  - dash = 3 units on
  - gap between elements of one character = 1 unit off
  - after the last element = 3 units off (CHARGAP)
  - word space (code 36) = 4 units off, giving 7 units total together with the preceding CHARGAP
- States:
  - IDLE: `char_ready`=1. Valid letter/digit → MARK (first element). Code 36 → SPACE. Invalid code → ERR.
  - MARK: `key_out`=1 for 1 or 3 units. If elements remain → GAP, else → CHARGAP.
  - GAP: `key_out`=0 for 1 unit → MARK (next element).
  - CHARGAP: `key_out`=0 for 3 units → IDLE.
  - SPACE: `key_out`=0 for 4 units → IDLE.
  - ERR: one cycle. `err`=1 and `key_out`=0 → IDLE.
- Unit counting: the cycle counter runs 0..UNIT_CYCLES-1 and wraps, then increments the unit count. The state advances on the edge where the required unit count is completed. Both counters clear on every state change.
- Asserting reset at any time forces `key_out`=0, `busy`=0 and state IDLE immediately (asynchronous). The character in progress is discarded and no `err` is issued.

## Timing
- `key_out` rises on the accept edge itself; the registered output is high in the cycle after acceptance. No extra pipeline delay.
- `busy` rises on the accept edge and falls on the edge that enters IDLE. `char_ready` goes high in the same cycle that `busy` falls.
- For a letter/digit, busy duration = UNIT_CYCLES × (sum of mark units + (len−1) gap units + 3).
- Word space busy duration = 4 × UNIT_CYCLES. Invalid code busy duration = 1 cycle.
- Back-to-back (`char_valid` held high): low time between the last mark of one character and the first mark of the next = 3 × UNIT_CYCLES + 1 cycles, i.e. CHARGAP plus the one mandatory IDLE cycle.
- `err` is high for exactly 1 cycle, the cycle after the accept edge.

## Test plan
All scenarios use UNIT_CYCLES=4.
- Reset: hold `rst`=0 for 20 cycles, then release → `key_out`=0, `busy`=0, `err`=0 during reset; `char_ready`=1 on the first cycle after release.
- Send E (code 4) → `key_out` high 4 cycles, then low 12 cycles; `busy` high 16 cycles; `char_ready` returns after 16 cycles.
- Send A (code 0) → `key_out` pattern 4 high, 4 low, 12 high, 12 low; `busy` high 32 cycles. Send 0 (code 26) → five 12-cycle marks separated by 4-cycle gaps, then 12 low; 88 cycles total.
- Back-to-back E then T with `char_valid` held high → E mark of 4 cycles, 13 low cycles, T mark of 12 cycles. Changing `char_code` while busy has no effect on the current character.
- Word space (code 36) → `key_out` stays 0, `busy` high 16 cycles. Code 50 → `err` pulse of 1 cycle, `key_out` stays 0, `char_ready` back after 1 cycle.
- Reset mid-operation: assert `rst`=0 during the second mark of A → `key_out` drops to 0 without waiting for a clock edge. After release: IDLE, `char_ready`=1, no residual pattern and no `err`.
